pixel_rmw_engine: RTL
=====================

# pixel_rmw_engine

Responder end of the screen-region protocol used by the triangle rasteriser. It accepts a bounding-box request and walks every on-screen pixel in row-major order. For each pixel it reads the old colour from the SDRAM framebuffer over an Avalon-MM master, presents `current_x`/`current_y`/`old_color` to the initiator, and captures `new_color`. It then writes that colour back and pulses `done` when the region is finished. It sits between the drawing primitives and the SDRAM controller inside the system interconnect.

## Interface
- `COORD_W`, 16, coordinate/length width
- `DATA_W`, 32, pixel colour width (ARGB)
- `ADDR_W`, 32, Avalon byte-address width
- `SCREEN_WIDTH`, 640, pixels per row; also the framebuffer stride
- `SCREEN_HEIGHT`, 480, rows
- `SHADE_CYCLES`, 1, cycles `old_color` is held before `new_color` is sampled (1..15)

- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `x_start`, `y_start`  in  COORD_W  region origin
- `x_length`, `y_length`  in  COORD_W  region size in pixels; 0 = empty
- `base_addr_offset`  in  ADDR_W  framebuffer byte base
- `new_color`  in  DATA_W  initiator's shaded colour
- `current_x`, `current_y`  out  COORD_W  pixel being shaded
- `old_color`  out  DATA_W  framebuffer colour at the current pixel
- `done`  out  1  one-cycle completion pulse
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `avm_address`  out  ADDR_W
- `avm_read`, `avm_write`  out  1
- `avm_writedata`  out  DATA_W
- `avm_byteenable`  out  DATA_W/8  constant all-ones
- `avm_waitrequest`  in  1
- `avm_readdata`  in  DATA_W
- `avm_readdatavalid`  in  1

## Operation
- On `start` in IDLE, latch all region inputs and the base address. Later input changes are ignored until `done`. `start` while busy is ignored.
- Iteration order: x from `x_start` to `x_start+x_length-1` (inner loop), then y likewise (outer loop).
- End sums are computed at COORD_W+1 bits, so they do not wrap.
- Pixels with x ≥ SCREEN_WIDTH or y ≥ SCREEN_HEIGHT are skipped: no bus access and not presented.
- Address = base + (y·SCREEN_WIDTH + x)·(DATA_W/8), truncated to ADDR_W.
- State machine:
  - IDLE: on `start`, go to NEXT.
  - NEXT: select the first or next unclipped pixel. If none remains, go to DONE; otherwise go to READ_REQ.
  - READ_REQ: assert `avm_read` with address held until `avm_waitrequest`=0, then go to READ_WAIT.
  - READ_WAIT: on `avm_readdatavalid`, register `avm_readdata` into `old_color` and go to SHADE.
  - SHADE: count SHADE_CYCLES, sample `new_color` on the last cycle, then go to WRITE_REQ.
  - WRITE_REQ: assert `avm_write` with the same address and the sampled colour until `avm_waitrequest`=0, then go to NEXT.
  - DONE: assert `done` for one cycle, then go to IDLE.
- At most one outstanding transaction; `avm_read` and `avm_write` are never high together.
- `current_x`/`current_y` update on entry to READ_REQ and hold through WRITE_REQ. `old_color` holds from SHADE entry through WRITE_REQ.
- Empty region (either length 0, or fully clipped): no bus traffic; `done` still pulses.

## Timing
- Reset values: all outputs 0; state IDLE; latched registers 0.
- Reset mid-operation aborts immediately. A late `avm_readdatavalid` arriving in IDLE is ignored.
- Cycle map, with `start` sampled high at edge N:
  - N+1: `busy`=1, NEXT.
  - N+2: `avm_read`=1.
- Per-pixel cost with zero waitrequest and read latency L: 1 (NEXT) + 1 (READ_REQ) + L + SHADE_CYCLES + 1 (WRITE_REQ) cycles.
- Empty region: `done`=1 at N+2, `busy` low at N+3.
- `new_color` must be valid by the final SHADE cycle. It may be a combinational function of `current_*`/`old_color`.
- `busy` falls in the cycle after `done`. A new `start` is accepted the cycle `busy` is low.

## Structure
- Package `pixel_rmw_pkg`: state enum (IDLE, NEXT, READ_REQ, READ_WAIT, SHADE, WRITE_REQ, DONE) and a bytes-per-pixel constant.
- Sub-module `pixel_addr_gen`: combinational address from x, y, base and stride. The constant-stride multiply is implemented as shift-add.
- The clip/iteration counters stay in the top-level module.

## Test plan
- Region (2,3) size 3×2, base 0, memory preloaded with address-as-data, shader returns old+1:
  - reads then writes hit bytes 7688, 7692, 7696, 10248, 10252, 10256 in that order;
  - each word increments by 1;
  - exactly one `done`.
- `x_length`=0: no `avm_read`/`avm_write`; `done` exactly at N+2.
- Region (638,479) size 4×3: only (638,479) and (639,479) are accessed; pixels with y=480 or 481 are skipped.
- Random `avm_waitrequest` (50%) and read latency 1..8: address, data and commands stay stable while stalled; results are identical to the zero-stall run.
- Assert `reset` during READ_WAIT, then return a stray `avm_readdatavalid`:
  - outputs go to 0 at once; no write occurs;
  - a following `start` for a 1×1 region completes normally.
- `start` pulsed again mid-region with different coordinates: ignored; the original region completes unchanged.

Source files
------------

// File: rtl/pixel_rmw_pkg.sv
// Shared types and constants for the pixel read-modify-write engine.
package pixel_rmw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NEXT,
    READ_REQ,
    READ_WAIT,
    SHADE,
    WRITE_REQ,
    DONE
  } state_e;

  // One ARGB pixel occupies one 32-bit framebuffer word.
  localparam int unsigned BYTES_PER_PIXEL = 4;

endpackage

// File: rtl/pixel_addr_gen.sv
// Framebuffer byte address of pixel (x, y): base + (y*STRIDE + x)*BYTES.
// The row multiply is a sum of shifted copies of y, one per set stride bit.
module pixel_addr_gen
  import pixel_rmw_pkg::*;
#(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned STRIDE  = 640,
  parameter int unsigned BYTES   = BYTES_PER_PIXEL
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [ADDR_W-1:0]  base,
  output logic [ADDR_W-1:0]  addr
);

  localparam int unsigned BYTE_SHIFT = $clog2(BYTES);

  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] pix_idx;

  // Shift-add row offset, then scale the pixel index to bytes.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so each partial sum is
    // visible to the next loop iteration within the same evaluation.
    row_off = '0;
    for (int i = 0; i < 32; i++) begin
      if (STRIDE[i]) row_off = row_off + (ADDR_W'(y) << i);
    end
    pix_idx = row_off + ADDR_W'(x);
    addr    = base + (pix_idx << BYTE_SHIFT);
  end

endmodule

// File: rtl/pixel_rmw_engine.sv
// Walks a clipped bounding box in row-major order, reading each pixel from
// the framebuffer, handing it to the shader and writing the result back.
module pixel_rmw_engine
  import pixel_rmw_pkg::*;
#(
  parameter int unsigned COORD_W       = 16,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned SHADE_CYCLES  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [COORD_W-1:0]  x_start,
  input  logic [COORD_W-1:0]  y_start,
  input  logic [COORD_W-1:0]  x_length,
  input  logic [COORD_W-1:0]  y_length,
  input  logic [ADDR_W-1:0]   base_addr_offset,
  input  logic [DATA_W-1:0]   new_color,
  output logic [COORD_W-1:0]  current_x,
  output logic [COORD_W-1:0]  current_y,
  output logic [DATA_W-1:0]   old_color,
  output logic                done,
  output logic                busy,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  // Coordinates are tracked one bit wider so region end sums never wrap.
  localparam int unsigned        EXT_W      = COORD_W + 1;
  localparam logic [EXT_W-1:0]   SCR_W      = EXT_W'(SCREEN_WIDTH);
  localparam logic [EXT_W-1:0]   SCR_H      = EXT_W'(SCREEN_HEIGHT);
  localparam logic [3:0]         SHADE_LAST = 4'(SHADE_CYCLES - 1);

  state_e             state_q,     state_d;
  logic [COORD_W-1:0] xs_q,        xs_d;
  logic [EXT_W-1:0]   xe_q,        xe_d;
  logic [EXT_W-1:0]   ye_q,        ye_d;
  logic [ADDR_W-1:0]  base_q,      base_d;
  logic [EXT_W-1:0]   ix_q,        ix_d;
  logic [EXT_W-1:0]   iy_q,        iy_d;
  logic [COORD_W-1:0] cur_x_q,     cur_x_d;
  logic [COORD_W-1:0] cur_y_q,     cur_y_d;
  logic [DATA_W-1:0]  old_q,       old_d;
  logic [DATA_W-1:0]  wdata_q,     wdata_d;
  logic [3:0]         shade_cnt_q, shade_cnt_d;

  logic             x_ok, y_ok, xs_ok, ny_ok;
  logic [EXT_W-1:0] ny;

  // Clip tests for the iterator position and for the start of the next row.
  // Columns are contiguous, so once x fails in a row the rest of it fails too.
  always_comb begin
    ny    = iy_q + 1'b1;
    x_ok  = (ix_q < xe_q) && (ix_q < SCR_W);
    y_ok  = (iy_q < ye_q) && (iy_q < SCR_H);
    ny_ok = (ny < ye_q) && (ny < SCR_H);
    xs_ok = ({1'b0, xs_q} < xe_q) && ({1'b0, xs_q} < SCR_W);
  end

  // Next-state and datapath update for the walk / read / shade / write loop.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ye_d        = ye_q;
    base_d      = base_q;
    ix_d        = ix_q;
    iy_d        = iy_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    old_d       = old_q;
    wdata_d     = wdata_q;
    shade_cnt_d = shade_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          xs_d    = x_start;
          xe_d    = {1'b0, x_start} + {1'b0, x_length};
          ye_d    = {1'b0, y_start} + {1'b0, y_length};
          base_d  = base_addr_offset;
          ix_d    = {1'b0, x_start};
          iy_d    = {1'b0, y_start};
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (y_ok && x_ok) begin
          cur_x_d = ix_q[COORD_W-1:0];
          cur_y_d = iy_q[COORD_W-1:0];
          ix_d    = ix_q + 1'b1;
          state_d = READ_REQ;
        end else if (y_ok && ny_ok && xs_ok) begin
          cur_x_d = xs_q;
          cur_y_d = ny[COORD_W-1:0];
          ix_d    = {1'b0, xs_q} + 1'b1;
          iy_d    = ny;
          state_d = READ_REQ;
        end else begin
          state_d = DONE;
        end
      end
      READ_REQ: begin
        if (!avm_waitrequest) state_d = READ_WAIT;
      end
      READ_WAIT: begin
        if (avm_readdatavalid) begin
          old_d       = avm_readdata;
          shade_cnt_d = '0;
          state_d     = SHADE;
        end
      end
      SHADE: begin
        if (shade_cnt_q == SHADE_LAST) begin
          wdata_d = new_color;
          state_d = WRITE_REQ;
        end else begin
          shade_cnt_d = shade_cnt_q + 4'd1;
        end
      end
      WRITE_REQ: begin
        if (!avm_waitrequest) state_d = NEXT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any region in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      xs_q        <= '0;
      xe_q        <= '0;
      ye_q        <= '0;
      base_q      <= '0;
      ix_q        <= '0;
      iy_q        <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      old_q       <= '0;
      wdata_q     <= '0;
      shade_cnt_q <= '0;
    end else begin
      // NOTE: registers use non-blocking '<=' so all flops sample the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
      base_q      <= base_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      old_q       <= old_d;
      wdata_q     <= wdata_d;
      shade_cnt_q <= shade_cnt_d;
    end
  end

  pixel_addr_gen #(
    .COORD_W(COORD_W),
    .ADDR_W (ADDR_W),
    .STRIDE (SCREEN_WIDTH),
    .BYTES  (DATA_W / 8)
  ) u_addr_gen (
    .x   (cur_x_q),
    .y   (cur_y_q),
    .base(base_q),
    .addr(avm_address)
  );

  assign current_x      = cur_x_q;
  assign current_y      = cur_y_q;
  assign old_color      = old_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = '1;
  assign avm_read       = (state_q == READ_REQ);
  assign avm_write      = (state_q == WRITE_REQ);
  assign done           = (state_q == DONE);
  assign busy           = (state_q != IDLE);

endmodule
